// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, sequencer states and bus source encodings shared by the ALU sequencer
package alu_seq_pkg;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  typedef enum logic [2:0] {IDLE, LOAD_Y, EXEC, WB_LO, WB_HI, DONE} stateT;
  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_REG  = 2'd1;
  localparam logic [1:0] BUS_ZLO  = 2'd2;
  localparam logic [1:0] BUS_ZHI  = 2'd3;
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: classifies an ALU opcode as legal, unary (no B operand) and mul/div
module alu_op_decode
  import alu_seq_pkg::*;
(
  input  logic [4:0] op,
  output logic       legal,
  output logic       unary,
  output logic       muldiv
);
  always_comb begin
    unary  = op inside {OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL, OP_NEG, OP_NOT};
    muldiv = op inside {OP_MUL, OP_DIV};
    legal  = unary | muldiv | (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR});
  end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: Moore sequencer driving load-Y / execute-into-Z / write-back for the shared ALU datapath
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int MULDIV_CYCLES = 1
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       start,
  input  logic [4:0] op,
  input  logic [3:0] ra,
  input  logic [3:0] rb,
  input  logic [3:0] rc,
  output logic       busy,
  output logic       done,
  output logic       illegal,
  output logic [1:0] bus_src,
  output logic [3:0] reg_out_sel,
  output logic       y_in,
  output logic       z_in,
  output logic       reg_in,
  output logic       lo_in,
  output logic       hi_in,
  output logic [3:0] reg_in_sel,
  output logic [4:0] alu_control
);
  localparam int CW = $clog2(MULDIV_CYCLES + 1);
  stateT state, nextState;
  logic [4:0] opQ;
  logic [3:0] raQ, rbQ, rcQ;
  logic unaryQ, muldivQ, illegalQ;
  logic [CW-1:0] cnt;
  logic opLegal, opUnary, opMuldiv;
  logic accept;
  alu_op_decode dec (.op(op), .legal(opLegal), .unary(opUnary), .muldiv(opMuldiv));
  assign accept = state == IDLE && start && opLegal;
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state    <= IDLE;
      opQ      <= '0;
      raQ      <= '0;
      rbQ      <= '0;
      rcQ      <= '0;
      unaryQ   <= 1'b0;
      muldivQ  <= 1'b0;
      illegalQ <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= nextState;
      illegalQ <= state == IDLE && start && !opLegal;
      if (accept) begin
        opQ     <= op;
        raQ     <= ra;
        rbQ     <= rb;
        rcQ     <= rc;
        unaryQ  <= opUnary;
        muldivQ <= opMuldiv;
      end
      // loaded on the LOAD_Y->EXEC transition; EXEC leaves when it reaches zero
      cnt <= (state == LOAD_Y) ? (muldivQ ? CW'(MULDIV_CYCLES - 1) : '0)
           : (state == EXEC && cnt != '0) ? cnt - CW'(1) : cnt;
    end
  end
  always_comb begin
    nextState   = state;
    bus_src     = BUS_NONE;
    reg_out_sel = '0;
    y_in        = 1'b0;
    z_in        = 1'b0;
    reg_in      = 1'b0;
    lo_in       = 1'b0;
    hi_in       = 1'b0;
    reg_in_sel  = '0;
    alu_control = '0;
    done        = 1'b0;
    busy        = state != IDLE;
    illegal     = illegalQ;
    case (state)
      IDLE: nextState = accept ? LOAD_Y : IDLE;
      LOAD_Y: begin
        bus_src     = BUS_REG;
        reg_out_sel = raQ;
        y_in        = 1'b1;
        nextState   = EXEC;
      end
      EXEC: begin
        alu_control = opQ;
        z_in        = 1'b1;
        bus_src     = unaryQ ? BUS_NONE : BUS_REG;
        reg_out_sel = unaryQ ? 4'd0 : rbQ;
        nextState   = cnt == '0 ? WB_LO : EXEC;
      end
      WB_LO: begin
        bus_src    = BUS_ZLO;
        lo_in      = muldivQ;
        reg_in     = !muldivQ;
        reg_in_sel = muldivQ ? 4'd0 : rcQ;
        nextState  = muldivQ ? WB_HI : DONE;
      end
      WB_HI: begin
        bus_src   = BUS_ZHI;
        hi_in     = 1'b1;
        nextState = DONE;
      end
      DONE: begin
        done      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed and randomized checks of alu_sequencer against a cycle-trace model built from the opcode rules
module tb_alu_sequencer;
  localparam int MDC = 3;
  typedef struct packed {
    logic       busy;
    logic       done;
    logic       illegal;
    logic [1:0] busSrc;
    logic [3:0] regOutSel;
    logic       yIn;
    logic       zIn;
    logic       regIn;
    logic       loIn;
    logic       hiIn;
    logic [3:0] regInSel;
    logic [4:0] aluControl;
  } outT;
  logic clock = 1'b0, clear = 1'b0, start = 1'b0;
  logic [4:0] op = '0;
  logic [3:0] ra = '0, rb = '0, rc = '0;
  logic busy, done, illegal, y_in, z_in, reg_in, lo_in, hi_in;
  logic [1:0] bus_src;
  logic [3:0] reg_out_sel, reg_in_sel;
  logic [4:0] alu_control;
  outT obs;
  outT expQ[$];
  int checks = 0, errors = 0;
  alu_sequencer #(.MULDIV_CYCLES(MDC)) dut (
    .clock(clock), .clear(clear), .start(start), .op(op), .ra(ra), .rb(rb), .rc(rc),
    .busy(busy), .done(done), .illegal(illegal), .bus_src(bus_src), .reg_out_sel(reg_out_sel),
    .y_in(y_in), .z_in(z_in), .reg_in(reg_in), .lo_in(lo_in), .hi_in(hi_in),
    .reg_in_sel(reg_in_sel), .alu_control(alu_control)
  );
  assign obs = {busy, done, illegal, bus_src, reg_out_sel, y_in, z_in, reg_in, lo_in, hi_in, reg_in_sel, alu_control};
  always #5 clock = ~clock;
  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end
  function automatic bit isUnary(input logic [4:0] o);
    return o == 5'd7 || o == 5'd8 || o == 5'd9 || o == 5'd10 || o == 5'd11 || o == 5'd17 || o == 5'd18;
  endfunction
  function automatic bit isMulDiv(input logic [4:0] o);
    return o == 5'd15 || o == 5'd16;
  endfunction
  function automatic bit isLegal(input logic [4:0] o);
    return isUnary(o) || isMulDiv(o) || (o >= 5'd3 && o <= 5'd6);
  endfunction
  // select lines only matter while their bus source or strobe is active
  function automatic outT norm(input outT v, input outT e);
    outT r = v;
    if (e.busSrc != 2'd1) r.regOutSel = '0;
    if (!e.regIn) r.regInSel = '0;
    return r;
  endfunction
  task automatic buildTrace(input logic [4:0] o, input logic [3:0] a, b, c);
    outT t;
    expQ.delete();
    if (!isLegal(o)) begin
      t = '0; t.illegal = 1'b1; expQ.push_back(t);
      t = '0; expQ.push_back(t);
      return;
    end
    t = '0; t.busy = 1; t.busSrc = 2'd1; t.regOutSel = a; t.yIn = 1; expQ.push_back(t);
    for (int i = 0; i < (isMulDiv(o) ? MDC : 1); i++) begin
      t = '0; t.busy = 1; t.zIn = 1; t.aluControl = o;
      if (!isUnary(o)) begin t.busSrc = 2'd1; t.regOutSel = b; end
      expQ.push_back(t);
    end
    t = '0; t.busy = 1; t.busSrc = 2'd2;
    if (isMulDiv(o)) t.loIn = 1; else begin t.regIn = 1; t.regInSel = c; end
    expQ.push_back(t);
    if (isMulDiv(o)) begin t = '0; t.busy = 1; t.busSrc = 2'd3; t.hiIn = 1; expQ.push_back(t); end
    t = '0; t.busy = 1; t.done = 1; expQ.push_back(t);
    t = '0; expQ.push_back(t);
  endtask
  task automatic runSeq(input string name, input logic [4:0] o, input logic [3:0] a, b, c);
    buildTrace(o, a, b, c);
    @(negedge clock);
    start = 1; op = o; ra = a; rb = b; rc = c;
    for (int k = 0; k < expQ.size(); k++) begin
      @(negedge clock);
      checks++;
      if (norm(obs, expQ[k]) !== expQ[k]) begin
        errors++;
        $display("FAIL %s op=%b cyc %0d got %h exp %h", name, o, k + 1, norm(obs, expQ[k]), expQ[k]);
      end
      start = expQ[k].busy ? 1'($urandom) : 1'b0;
      op = 5'($urandom); ra = 4'($urandom); rb = 4'($urandom); rc = 4'($urandom);
    end
    start = 0;
  endtask
  task automatic test_reset;
    #3;
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_async got %h exp 0", obs); end
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_held got %h exp 0", obs); end
    @(negedge clock);
    clear = 1;
    @(negedge clock);
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_release got %h exp 0", obs); end
  endtask
  task automatic test_add;
    runSeq("add", 5'b00011, 4'd2, 4'd3, 4'd4);
  endtask
  task automatic test_not;
    runSeq("not", 5'b10010, 4'd5, 4'd6, 4'd7);
  endtask
  task automatic test_mul;
    runSeq("mul", 5'b01111, 4'd8, 4'd9, 4'd10);
  endtask
  task automatic test_illegal;
    runSeq("illegal", 5'b01100, 4'd1, 4'd1, 4'd1);
    runSeq("after_illegal", 5'b00100, 4'd11, 4'd12, 4'd13);
  endtask
  task automatic test_back_to_back;
    @(negedge clock);
    start = 1; op = 5'b00011; ra = 4'd1; rb = 4'd2; rc = 4'd3;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      checks++;
      if (done !== (k == 4 || k == 9) || busy !== !(k == 5 || k == 10)) begin
        errors++;
        $display("FAIL back_to_back cyc %0d got done=%b busy=%b exp done=%b busy=%b", k, done, busy, k == 4 || k == 9, !(k == 5 || k == 10));
      end
    end
    start = 0;
    @(negedge clock);
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL back_to_back_idle got %h exp 0", obs); end
  endtask
  task automatic test_clear;
    @(negedge clock);
    start = 1; op = 5'b10000; ra = 4'd3; rb = 4'd4; rc = 4'd5;
    @(negedge clock);
    start = 0;
    checks++;
    if (y_in !== 1'b1) begin errors++; $display("FAIL clear_loady got y_in=%b exp 1", y_in); end
    @(negedge clock);
    checks++;
    if (z_in !== 1'b1 || alu_control !== 5'b10000) begin
      errors++; $display("FAIL clear_exec got z_in=%b alu=%b exp 1 10000", z_in, alu_control);
    end
    #2 clear = 0;
    #1;
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL clear_async got %h exp 0", obs); end
    @(negedge clock);
    clear = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      checks++;
      if (obs !== '0) begin errors++; $display("FAIL clear_after cyc %0d got %h exp 0", k, obs); end
    end
    runSeq("after_clear", 5'b00101, 4'd14, 4'd15, 4'd0);
  endtask
  task automatic test_random;
    logic [4:0] o;
    for (int i = 0; i < 40; i++) begin
      o = 5'($urandom);
      if (i % 4 != 0 && !isLegal(o)) o = 5'd3 + 5'($urandom_range(0, 15));
      runSeq("random", o, 4'($urandom), 4'($urandom), 4'($urandom));
    end
  endtask
  initial begin
    test_reset;
    test_add;
    test_not;
    test_mul;
    test_illegal;
    test_back_to_back;
    test_clear;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multicycle control sequencer for the shared 32-bit ALU datapath (Y register, ALU, 64-bit Z register, LO/HI registers, register file). On a `start` request it accepts one ALU operation. It then drives the bus source select, register strobes and `ALUControl` through a fixed Moore state sequence: load Y, execute into Z, write back. It signals completion with a one-cycle `done` pulse. It sits between the instruction control unit and the datapath and is the only driver of Y/Z/LO/HI load strobes.

## Interface
- `MULDIV_CYCLES`, default 1: cycles EXEC is held for mul/div (≥1), reserving room for an iterative multiplier/divider.
- `clock` in 1: single clock; all state updates on the rising edge.
- `clear` in 1: reset, asynchronous, active-low. Asserted when 0.
- `start` in 1: operation request, sampled only in IDLE.
- `op` in 5: ALU opcode, latched on accept.
- `ra`, `rb`, `rc` in 4 each: source A, source B and destination register indices, latched on accept.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse in DONE.
- `illegal` out 1: one-cycle pulse when an unsupported opcode is rejected.
- `bus_src` out 2: 0 none, 1 register file, 2 ZLow, 3 ZHigh.
- `reg_out_sel` out 4: register driven when `bus_src`=1.
- `y_in`, `z_in`, `reg_in`, `lo_in`, `hi_in` out 1 each: load strobes.
- `reg_in_sel` out 4: destination register when `reg_in`=1.
- `alu_control` out 5: opcode driven to ALU.

## Operation
- Legal opcodes:
  - binary: add 00011, sub 00100, and 00101, or 00110, mul 01111, div 10000.
  - unary (B unused): shr 00111, shra 01000, shl 01001, ror 01010, rol 01011, neg 10001, not 10010.
  - All other opcodes are illegal.
- States: IDLE, LOAD_Y, EXEC, WB_LO, WB_HI, DONE.
- IDLE:
  - `start`=1 with a legal op: latch `op`/`ra`/`rb`/`rc` and go to LOAD_Y.
  - `start`=1 with an illegal op: pulse `illegal` next cycle and stay in IDLE. No strobes, no `done`.
- LOAD_Y: `bus_src`=1, `reg_out_sel`=ra, `y_in`=1. Next state is EXEC.
- EXEC:
  - `alu_control`=op and `z_in`=1 on every EXEC cycle.
  - Binary ops: `bus_src`=1, `reg_out_sel`=rb. Unary ops: `bus_src`=0.
  - Non-mul/div ops: EXEC lasts 1 cycle.
  - mul/div: EXEC lasts MULDIV_CYCLES cycles, counted by a down-counter loaded on entry.
  - Next state is WB_LO.
- WB_LO:
  - `bus_src`=2.
  - mul/div: `lo_in`=1, next state WB_HI.
  - Otherwise: `reg_in`=1, `reg_in_sel`=rc, next state DONE.
- WB_HI: `bus_src`=3, `hi_in`=1. Next state is DONE.
- DONE: `done`=1. Next state is IDLE.
- `start` outside IDLE is ignored; no queueing.
- `alu_control` is 00000 in every state except EXEC.

## Timing
- Reset values (while `clear`=0, and on its release): state IDLE, every output 0, counter 0, latched fields 0.
- All outputs are decoded from registered state and latched fields only. There are no combinational paths from `start`, `op` or the register indices to any output.
- Latency, counted from the accepting edge to the edge at which `done` is high:
  - non-mul/div ops: 4 cycles.
  - mul/div: 4 + MULDIV_CYCLES cycles.
- Back-to-back: `start` asserted during DONE is ignored. The next operation is accepted on the IDLE cycle that follows DONE.
- Asserting `clear` mid-operation aborts the operation immediately and asynchronously. Strobes drop in the same instant. No `done` is issued.
- An illegal op is followed by `illegal` high for exactly one cycle, with `busy` staying 0.

## Structure
- Package `alu_seq_pkg`:
  - the 13 opcode constants;
  - the state enum;
  - the `bus_src` encodings (NONE, REG, ZLO, ZHI).
- Sub-module `alu_op_decode`: combinational. Maps `op` to `legal`, `unary` and `muldiv` flags. It is shared with the future instruction decoder.
- Top level contains the state register, the latched fields, the EXEC counter and the output decode.

## Test plan
- Add: `op`=00011, `ra`=2, `rb`=3, `rc`=4.
  - Cycle 1: `y_in` with `reg_out_sel`=2.
  - Cycle 2: `z_in` with `reg_out_sel`=3 and `alu_control`=00011.
  - Cycle 3: `reg_in` with `reg_in_sel`=4 and `bus_src`=2.
  - Cycle 4: `done`.
- Not: `op`=10010. In EXEC, `bus_src`=0 and `alu_control`=10010. Cycle 4 `done`.
- Mul with MULDIV_CYCLES=3: `op`=01111.
  - `z_in` high for 3 cycles.
  - `lo_in`, then `hi_in` (`bus_src`=3), then `done` at cycle 7.
  - `reg_in` is never asserted.
- Illegal: `op`=01100.
  - `illegal` pulses once.
  - `busy`, all strobes and `done` stay 0.
  - A subsequent legal `start` is accepted normally.
- `start` held high throughout two add operations: the second is accepted in the IDLE cycle after DONE. `done` pulses at cycles 4 and 9.
- `clear` dropped to 0 during EXEC of a div:
  - all outputs go to 0 asynchronously;
  - no `done` is issued;
  - after release the sequencer is in IDLE and accepts a new op.
